// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: fetch (IF) and data (D) requesters share one
// memory port. Round-robin on collisions, bounded wait for the memory
// acknowledge, and a one-cycle response pulse to the granted requester.
// All outputs come straight from flops.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ack_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              err_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Counter value seen during the last permitted GRANT cycle.
  localparam logic [15:0] TMO_LAST_C = 16'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO_C = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO_C = {DATA_W{1'b0}};

  state_t              state_r, state_s;
  logic                last_d_r, last_d_s;     // 1: last grant went to D, 0: to IF
  logic                gnt_d_r, gnt_d_s;       // owner of the current transaction
  logic [15:0]         cnt_r, cnt_s;
  logic                err_pend_r, err_pend_s;
  logic                pick_d_s;
  logic [DATA_W-1:0]   resp_data_s;

  // Output flops; the mem_* registers double as the captured request.
  logic                mem_req_r, mem_req_s;
  logic                mem_we_r, mem_we_s;
  logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
  logic [DATA_W-1:0]   mem_wdata_r, mem_wdata_s;
  logic                if_ack_r, if_ack_s;
  logic                d_ack_r, d_ack_s;
  logic [DATA_W-1:0]   if_rdata_r, if_rdata_s;
  logic [DATA_W-1:0]   d_rdata_r, d_rdata_s;
  logic                err_r, err_s;

  // Next-state and next-output decode for the arbitration FSM.
  always_comb begin
    state_s     = state_r;
    last_d_s    = last_d_r;
    gnt_d_s     = gnt_d_r;
    cnt_s       = cnt_r;
    err_pend_s  = err_pend_r;
    pick_d_s    = 1'b0;
    resp_data_s = DATA_ZERO_C;
    mem_req_s   = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = ADDR_ZERO_C;
    mem_wdata_s = DATA_ZERO_C;
    if_ack_s    = 1'b0;
    d_ack_s     = 1'b0;
    if_rdata_s  = DATA_ZERO_C;
    d_rdata_s   = DATA_ZERO_C;
    err_s       = 1'b0;

    case (state_r)
      IDLE: begin
        // D wins when alone, or on a collision when IF was served last.
        pick_d_s = d_req_i & (~if_req_i | ~last_d_r);
        if (if_req_i || d_req_i) begin
          state_s   = GRANT;
          gnt_d_s   = pick_d_s;
          last_d_s  = pick_d_s;
          cnt_s     = 16'd0;
          mem_req_s = 1'b1;
          if (pick_d_s) begin
            mem_we_s    = d_we_i;
            mem_addr_s  = d_addr_i;
            mem_wdata_s = d_wdata_i;
          end else begin
            mem_we_s    = 1'b0;
            mem_addr_s  = if_addr_i;
            mem_wdata_s = DATA_ZERO_C;
          end
        end else begin
          state_s = IDLE;
        end
      end

      GRANT: begin
        if (mem_ack_i) begin
          state_s     = RESP;
          err_pend_s  = 1'b0;
          resp_data_s = mem_we_r ? DATA_ZERO_C : mem_rdata_i;
          if_ack_s    = ~gnt_d_r;
          d_ack_s     = gnt_d_r;
          if_rdata_s  = gnt_d_r ? DATA_ZERO_C : resp_data_s;
          d_rdata_s   = gnt_d_r ? resp_data_s : DATA_ZERO_C;
          err_s       = 1'b0;
        end else if (cnt_r == TMO_LAST_C) begin
          // Memory never answered: complete with zero data and flag it.
          state_s     = RESP;
          err_pend_s  = 1'b1;
          resp_data_s = DATA_ZERO_C;
          if_ack_s    = ~gnt_d_r;
          d_ack_s     = gnt_d_r;
          err_s       = 1'b1;
        end else begin
          cnt_s       = cnt_r + 16'd1;
          mem_req_s   = 1'b1;
          mem_we_s    = mem_we_r;
          mem_addr_s  = mem_addr_r;
          mem_wdata_s = mem_wdata_r;
        end
      end

      RESP: begin
        state_s    = IDLE;
        err_pend_s = 1'b0;
      end

      default: begin
        state_s    = IDLE;
        err_pend_s = 1'b0;
      end
    endcase
  end

  // FSM state, round-robin pointer, timeout counter and error flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r    <= IDLE;
      last_d_r   <= 1'b0;
      gnt_d_r    <= 1'b0;
      cnt_r      <= 16'd0;
      err_pend_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      last_d_r   <= last_d_s;
      gnt_d_r    <= gnt_d_s;
      cnt_r      <= cnt_s;
      err_pend_r <= err_pend_s;
    end
  end

  // Registered outputs; reset clears them immediately, aborting any grant.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= ADDR_ZERO_C;
      mem_wdata_r <= DATA_ZERO_C;
      if_ack_r    <= 1'b0;
      d_ack_r     <= 1'b0;
      if_rdata_r  <= DATA_ZERO_C;
      d_rdata_r   <= DATA_ZERO_C;
      err_r       <= 1'b0;
    end else begin
      mem_req_r   <= mem_req_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      if_ack_r    <= if_ack_s;
      d_ack_r     <= d_ack_s;
      if_rdata_r  <= if_rdata_s;
      d_rdata_r   <= d_rdata_s;
      err_r       <= err_s;
    end
  end

  assign mem_req_o   = mem_req_r;
  assign mem_we_o    = mem_we_r;
  assign mem_addr_o  = mem_addr_r;
  assign mem_wdata_o = mem_wdata_r;
  assign if_ack_o    = if_ack_r;
  assign d_ack_o     = d_ack_r;
  assign if_rdata_o  = if_rdata_r;
  assign d_rdata_o   = d_rdata_r;
  assign err_o       = err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with a transaction-level reference model:
// round-robin winner, grant length min(k+1, TIMEOUT), response data rules.
module tb_mem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic          if_ack_o;
  logic          d_req_i;
  logic          d_we_i;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic [DW-1:0] d_rdata_o;
  logic          d_ack_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_ack_i;
  logic          err_o;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int   n_checks = 0;
  int   n_errors = 0;
  logic last_d_m = 1'b0;   // model: 1 when D was granted last

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check_val(tag, 64'({mem_req_o, mem_we_o, if_ack_o, d_ack_o, err_o,
                        |mem_addr_o, |mem_wdata_o, |if_rdata_o, |d_rdata_o}), 64'd0);
  endtask

  // Entered at a negedge with the DUT in IDLE; leaves at the IDLE negedge after RESP.
  // k: index of the GRANT cycle in which memory acks (k >= TMO means never).
  task automatic run_txn(input logic rq_if, input logic rq_d, input logic [31:0] ia,
                         input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
                         input int k, input logic [31:0] mdata, output logic win_d);
    logic        exp_we;
    logic [31:0] exp_addr, exp_wd, exp_rd;
    int          ncyc;
    logic        to;
    if_req_i = rq_if; if_addr_i = ia;
    d_req_i = rq_d; d_we_i = dwe; d_addr_i = da; d_wdata_i = dwd;
    mem_ack_i = 1'($urandom_range(0, 1));
    mem_rdata_i = $urandom;

    win_d    = rq_d && (!rq_if || !last_d_m);
    last_d_m = win_d;
    exp_we   = win_d ? dwe : 1'b0;
    exp_addr = win_d ? da : ia;
    exp_wd   = win_d ? dwd : 32'd0;
    to       = (k >= TMO);
    ncyc     = to ? TMO : k + 1;
    exp_rd   = (to || exp_we) ? 32'd0 : mdata;

    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk_i);
      check_val("grant_ctl", 64'({mem_req_o, mem_we_o, if_ack_o, d_ack_o, err_o}),
                64'({1'b1, exp_we, 3'b000}));
      check_val("grant_addr", 64'(mem_addr_o), 64'(exp_addr));
      check_val("grant_wdata", 64'(mem_wdata_o), 64'(exp_wd));
      check_val("grant_rdata_zero", 64'({|if_rdata_o, |d_rdata_o}), 64'd0);
      if (c == 0 && $urandom_range(0, 3) == 0) begin
        if (win_d) d_req_i = 1'b0;
        else if_req_i = 1'b0;
      end
      mem_ack_i   = (c == k);
      mem_rdata_i = (c == k) ? mdata : $urandom;
    end

    @(negedge clk_i);
    check_val("resp_ctl", 64'({mem_req_o, if_ack_o, d_ack_o, err_o}),
              64'({1'b0, !win_d, win_d, to}));
    check_val("resp_if_rdata", 64'(if_rdata_o), win_d ? 64'd0 : 64'(exp_rd));
    check_val("resp_d_rdata", 64'(d_rdata_o), win_d ? 64'(exp_rd) : 64'd0);
    mem_ack_i   = 1'($urandom_range(0, 1));
    mem_rdata_i = $urandom;

    @(negedge clk_i);
    check_idle("post_resp_idle");
  endtask

  logic        if_on, d_on, dwe, win;
  logic [31:0] ia, da, dwd;

  initial begin
    rst_i = 1'b0;
    if_req_i = 1'b0; if_addr_i = 32'd0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = 32'd0; d_wdata_i = 32'd0;
    mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
    #12;
    check_idle("reset_outputs");
    @(negedge clk_i);
    rst_i = 1'b1;

    // Simultaneous requests after reset: D write first, then the held IF read.
    run_txn(1'b1, 1'b1, 32'h100, 1'b1, 32'h40, 32'hDEADBEEF, 0, 32'h55AA55AA, win);
    run_txn(1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 32'h0, 3, 32'h12345678, win);

    // Continuous dual requests: alternates D, IF, D, IF.
    for (int i = 0; i < 4; i++)
      run_txn(1'b1, 1'b1, 32'h200 + 32'(i), 1'b0, 32'h300 + 32'(i), 32'd0,
              $urandom_range(0, 2), $urandom, win);

    // Timeout, then a normal transaction with err clear.
    run_txn(1'b0, 1'b1, 32'h0, 1'b0, 32'h500, 32'h0, 6, 32'hCAFEF00D, win);
    run_txn(1'b0, 1'b1, 32'h0, 1'b0, 32'h504, 32'h0, 1, 32'h0BADF00D, win);
    run_txn(1'b1, 1'b0, 32'h600, 1'b0, 32'h0, 32'h0, TMO - 1, 32'hA5A5A5A5, win);

    // Randomized traffic; a winner may keep its request high after ack.
    if_on = 1'b0; d_on = 1'b0; dwe = 1'b0;
    ia = 32'd0; da = 32'd0; dwd = 32'd0;
    repeat (40) begin
      if (!if_on && $urandom_range(0, 1) == 1) begin if_on = 1'b1; ia = $urandom; end
      if (!d_on && $urandom_range(0, 1) == 1) begin
        d_on = 1'b1; da = $urandom; dwd = $urandom; dwe = 1'($urandom_range(0, 1));
      end
      if (!if_on && !d_on) begin if_on = 1'b1; ia = $urandom; end
      run_txn(if_on, d_on, ia, dwe, da, dwd, $urandom_range(0, 5), $urandom, win);
      if (win) d_on = 1'($urandom_range(0, 1));
      else if_on = 1'($urandom_range(0, 1));
    end

    // Reset in the middle of a grant, then a stray memory ack.
    if_req_i = 1'b1; if_addr_i = 32'h700; d_req_i = 1'b0; mem_ack_i = 1'b0;
    @(negedge clk_i);
    check_val("pre_reset_grant", 64'(mem_req_o), 64'd1);
    #2 rst_i = 1'b0;
    #1 check_idle("reset_mid_grant");
    if_req_i = 1'b0;
    last_d_m = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'hFFFFFFFF;
    repeat (3) begin
      @(negedge clk_i);
      check_idle("stray_ack_ignored");
    end

    // Round-robin pointer back at IF after reset: D wins the collision.
    run_txn(1'b1, 1'b1, 32'h800, 1'b0, 32'h900, 32'h0, 0, 32'h13572468, win);
    run_txn(1'b1, 1'b0, 32'h800, 1'b0, 32'h0, 32'h0, 0, 32'h24681357, win);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
